// File: rtl/fir_input_feeder.sv
// Sample FIFO and issue sequencer in front of the 64-tap FIR core; one sample in flight at a time.
// Optional WAIT watchdog enabled by defining FEEDER_TIMEOUT_EN.
module fir_input_feeder #(
    parameter int unsigned InputWidth    = 16,
    parameter int unsigned FifoDepth     = 8,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [InputWidth-1:0]        s_data,
    output logic                         fir_inputValid,
    output logic [InputWidth-1:0]        fir_input,
    input  logic                         fir_outputValid,
    output logic                         busy,
    output logic [$clog2(FifoDepth):0]   fifo_count,
    output logic                         timeout_err
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [InputWidth-1:0] fir_input_q, fir_input_d;
    logic [InputWidth-1:0] mem_q [FifoDepth];

    logic push;
    logic pop;
    logic fifo_nonempty;
    logic timeout_hit;

    assign fifo_nonempty = (count_q != '0);
    assign s_ready       = (count_q != CntW'(FifoDepth));
    assign push          = s_valid && s_ready;
    assign fifo_count    = count_q;
    assign fir_input     = fir_input_q;

`ifdef FEEDER_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TimeoutCycles) + 1;

    logic [ToW-1:0] wait_cnt_q, wait_cnt_d;
    logic           timeout_err_q, timeout_err_d;

    // Counter sits at zero outside WAIT, so it is already cleared on entry.
    assign timeout_hit   = (state_q == WAIT) && !fir_outputValid
                           && (wait_cnt_q == ToW'(TimeoutCycles - 1));
    assign wait_cnt_d    = (state_q == WAIT) ? wait_cnt_q + 1'b1 : '0;
    assign timeout_err_d = timeout_err_q || timeout_hit;
    assign timeout_err   = timeout_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TimeoutCycles == 0);
    assign timeout_hit        = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and pop decision
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fifo_nonempty) begin
                    state_d = ISSUE;
                    pop     = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (fir_outputValid) begin
                    if (fifo_nonempty) begin
                        state_d = ISSUE;
                        pop     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        fir_inputValid = (state_q == ISSUE);
        busy           = (state_q != IDLE);
    end

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fir_input_d = pop  ? mem_q[rd_ptr_q] : fir_input_q;
        count_d     = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fir_input_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            fir_input_q <= fir_input_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

endmodule
